// File: rtl/multiplier_seq_16bits_pkg.sv
// Shared constants for the sequential multiply/divide blocks: FSM state encoding and default width.
package multiplier_seq_16bits_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/multiplier_seq_16bits_if.sv
// Start/done handshake bundle for the sequential multiplier; the master drives operands, the slave returns the product.
interface multiplier_seq_16bits_if #(
    parameter int WIDTH = 16
);
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH + 1);

    logic          start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;
    logic [IW-1:0] iter;

    modport master (
        output start, a, b,
        input  busy, done, product, iter
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, iter
    );

endinterface

// File: rtl/multiplier_seq_16bits_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier; one partial product per step.
// acc_nxt is the combinational result of the current step so the final sum can be captured on the last edge.
module mult_shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc_nxt
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    assign acc_nxt = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (step) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/multiplier_seq_16bits.sv
// Sequential unsigned shift-add multiplier: product valid WIDTH edges after an accepted start.
// Start is only taken in IDLE/DONE, so a held start re-launches the moment DONE is reached.
module multiplier_seq_16bits
    import multiplier_seq_16bits_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    multiplier_seq_16bits_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH + 1);

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [PW-1:0] product_q, product_d;
    logic [PW-1:0] acc_nxt;
    logic          dp_load, dp_step;

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (dp_load),
        .step    (dp_step),
        .a       (bus.a),
        .b       (bus.b),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = done_q;
        iter_d    = iter_q;
        product_d = product_q;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // product is deliberately left alone so the last result stays readable
                if (bus.start) begin
                    dp_load = 1'b1;
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    iter_d  = '0;
                end
            end
            ST_BUSY: begin
                dp_step = 1'b1;
                iter_d  = iter_q + IW'(1);
                if (iter_q == IW'(WIDTH - 1)) begin
                    product_d = acc_nxt;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            iter_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            iter_q    <= iter_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.iter    = iter_q;

endmodule

// File: tb/tb_multiplier_seq_16bits.sv
// Directed and random checks of the sequential multiplier: reset, latency, extremes, busy-time isolation, back-to-back.
module tb_multiplier_seq_16bits;
    localparam int WIDTH = 16;
    localparam int PW    = 2 * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multiplier_seq_16bits_if #(.WIDTH(WIDTH)) bus ();

    multiplier_seq_16bits #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts edges after acceptance until done, bounded so a stuck DUT shows up as a latency error.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.product !== 32'd0 || bus.iter !== 5'd0) begin
            errors++;
            $display("FAIL reset_data got product=%h iter=%0d want 0 0", bus.product, bus.iter);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        start_op(16'd1234, 16'd5678);
        repeat (4) tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.iter !== 5'd4) begin
            errors++;
            $display("FAIL midop_running got busy=%b iter=%0d want 1 4", bus.busy, bus.iter);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'd0 || bus.iter !== 5'd0) begin
            errors++;
            $display("FAIL midop_reset got busy=%b done=%b product=%h iter=%0d want all 0",
                     bus.busy, bus.done, bus.product, bus.iter);
        end
        done_seen = 0;
        repeat (30) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midop_no_residue got %0d active cycles want 0", done_seen);
        end
    endtask

    task automatic test_basic();
        int cyc, bsy;
        start_op(16'd300, 16'd200);
        wait_done(cyc, bsy);
        checks++;
        if (cyc != 16 || bsy != 16) begin
            errors++;
            $display("FAIL basic_latency got cycles=%0d busy=%0d want 16 16", cyc, bsy);
        end
        checks++;
        if (bus.product !== 32'd60000) begin
            errors++;
            $display("FAIL basic_product got %0d want 60000", bus.product);
        end
        checks++;
        if (bus.iter !== 5'd16 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_iter got iter=%0d busy=%b want 16 0", bus.iter, bus.busy);
        end
        repeat (3) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.product !== 32'd60000) begin
            errors++;
            $display("FAIL basic_hold got done=%b product=%0d want 1 60000", bus.done, bus.product);
        end
    endtask

    task automatic test_extremes();
        int cyc, bsy;
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(cyc, bsy);
        checks++;
        if (cyc != 16 || bus.product !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL max_product got cycles=%0d product=%h want 16 fffe0001", cyc, bus.product);
        end
        start_op(16'h0000, 16'hABCD);
        checks++;
        if (bus.done !== 1'b0 || bus.product !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL restart_hold got done=%b product=%h want 0 fffe0001", bus.done, bus.product);
        end
        wait_done(cyc, bsy);
        checks++;
        if (cyc != 16 || bus.product !== 32'd0) begin
            errors++;
            $display("FAIL zero_product got cycles=%0d product=%h want 16 0", cyc, bus.product);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, bsy;
        start_op(16'd1000, 16'd3000);
        repeat (7) tick();
        bus.a     = 16'd5;
        bus.b     = 16'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc, bsy);
        checks++;
        if (cyc != 8 || bus.product !== 32'd3000000) begin
            errors++;
            $display("FAIL busy_ignore got remaining=%0d product=%0d want 8 3000000", cyc, bus.product);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bsy;
        bus.a     = 16'd7;
        bus.b     = 16'd9;
        bus.start = 1'b1;
        tick();
        wait_done(cyc, bsy);
        checks++;
        if (cyc != 16 || bus.product !== 32'd63) begin
            errors++;
            $display("FAIL b2b_first got cycles=%0d product=%0d want 16 63", cyc, bus.product);
        end
        bus.a = 16'd65535;
        bus.b = 16'd2;
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.product !== 32'd63) begin
            errors++;
            $display("FAIL b2b_pulse got done=%b busy=%b product=%0d want 0 1 63", bus.done, bus.busy, bus.product);
        end
        wait_done(cyc, bsy);
        bus.start = 1'b0;
        checks++;
        if (cyc != 16 || bus.product !== 32'd131070) begin
            errors++;
            $display("FAIL b2b_second got cycles=%0d product=%0d want 16 131070", cyc, bus.product);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.product !== 32'd131070) begin
            errors++;
            $display("FAIL b2b_stay_done got done=%b product=%0d want 1 131070", bus.done, bus.product);
        end
    endtask

    task automatic test_random();
        int cyc, bsy;
        logic [15:0] av, bv;
        logic [PW-1:0] expv;
        for (int n = 0; n < 1000; n++) begin
            av   = 16'($urandom_range(0, 65535));
            bv   = 16'($urandom_range(0, 65535));
            expv = {16'd0, av} * {16'd0, bv};
            start_op(av, bv);
            wait_done(cyc, bsy);
            checks++;
            if (cyc != 16 || bus.product !== expv) begin
                errors++;
                $display("FAIL rand_product a=%0d b=%0d got cycles=%0d product=%0d want 16 %0d",
                         av, bv, cyc, bus.product, expv);
            end
            checks++;
            if (bus.iter !== 5'd16) begin
                errors++;
                $display("FAIL rand_iter got %0d want 16", bus.iter);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_reset_mid_op();
        test_basic();
        test_extremes();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_seq_16bits.md
Name: multiplier_seq_16bits

Overview:
- Sequential shift-add unsigned integer multiplier. It is the inverse-operation companion of the team's sequential 16-bit divider.
- Takes two WIDTH-bit operands on a start handshake and produces a 2*WIDTH-bit product after WIDTH iterations.
- Sits behind the same board-level start/done wrapper style as the divider. Product and status feed the 7-segment/LED display logic.

Parameters:
- WIDTH, 16: operand width in bits. The product is 2*WIDTH bits. Legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  multiplicand; captured on the accepted start.
- b  input  WIDTH  multiplier; captured on the accepted start.
- busy  output  1  high while iterating.
- done  output  1  high from completion until the next accepted start or reset.
- product  output  2*WIDTH  result; valid while done=1.
- iter  output  $clog2(WIDTH+1)  iteration count, for LED progress display.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - state<=IDLE;
  - busy, done, product, iter, and the internal accumulator and operand registers all <=0.
  - Reset has priority over everything, including mid-operation. An aborted operation leaves no residue, and done stays 0.
- IDLE state: busy=0, done=0.
  - start=1 at edge k: latch a into mcand_r (zero-extended to 2*WIDTH) and b into mplier_r; acc<=0; iter<=0; state<=BUSY.
- BUSY state: busy=1, done=0. At each edge:
  - if mplier_r[0]=1, then acc<=acc+mcand_r (2*WIDTH-bit add, no overflow possible);
  - mcand_r<=mcand_r<<1; mplier_r<=mplier_r>>1; iter<=iter+1.
  - start is ignored, and a/b changes have no effect.
- BUSY to DONE: on the edge where iter transitions WIDTH-1 -> WIDTH, the final accumulate is written into product (product<=acc plus the final add), done<=1, busy<=0, state<=DONE.
- Latency: start accepted at edge k gives done=1 and a valid product visible after edge k+WIDTH (16 cycles for the default).
- No early termination: latency is fixed regardless of operand values, including zero operands.
- DONE state: done=1, product and iter held.
  - start=1 at an edge: same action as IDLE acceptance; done<=0 on that edge, product is held until overwritten at the next completion, state<=BUSY. This allows back-to-back operations with zero idle cycles.
  - start=0: remain in DONE indefinitely.
- Unused state encodings recover to IDLE on the next edge.
- Arithmetic:
  - unsigned only;
  - maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits;
  - a=0 or b=0 yields product=0 at normal latency.
- start held high continuously: accepted at the first edge in IDLE, then re-accepted each time DONE is reached. done is therefore high for exactly one cycle per operation.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - default WIDTH constant, shared with the divider.
- One natural sub-module, mult_shift_add_dp: the datapath holding the acc/mcand/mplier registers, with load and step enables.
- The top holds the FSM and the iteration counter. The board wrapper (7-seg/LED mapping) is a separate, existing-style module and is not part of this block.

Test Plan:
- Reset mid-operation: start with a=16'd1234, b=16'd5678, assert rst at cycle 5 -> all outputs 0, state IDLE, no done pulse afterward without a new start.
- Basic multiply: a=16'd300, b=16'd200, start one cycle -> busy=1 for 16 cycles, done=1 exactly 16 edges after acceptance, product=32'd60000.
- Maximum operands: a=b=16'hFFFF -> product=32'hFFFE0001. Zero operand a=0, b=16'hABCD -> product=0 at the same 16-cycle latency.
- start and operand changes during BUSY: pulse start and change a/b at cycle 8 -> ignored, result matches the originally captured operands.
- Back-to-back: hold start=1 with a=7, b=9, then a=16'd65535, b=2 switched in the DONE cycle -> done high one cycle with product=63, next done 16 cycles later with product=32'd131070.
- Random regression: 1000 random a/b pairs, result compared against a*b reference model; iter reads WIDTH while done=1.
